// File: rtl/cu_pkg.sv
// Shared definitions for the hardwired control unit: FSM state encoding,
// opcode map, datapath control codes and instruction field extraction.
// Instruction formats:
//   branch/memory : [15:10] opcode, [9:8] RSEL, [7:0] ADDR
//   ALU           : [15:10] opcode, [9] S, [8:6] DST, [5:3] SRC1, [2:0] SRC2
// Operand codes 4-7 name R1-R4; codes 0-3 name ARF registers (00/01 PC, 10 AR, 11 SP).
package cu_pkg;

    localparam int unsigned T_W    = 3;
    localparam int unsigned OPC_W  = 6;
    localparam int unsigned IR_W   = 16;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned FLAG_Z = 3;  // FlagsOut = {Z,C,N,O}

    // Defensive ceiling on execute length; no opcode legitimately reaches it.
    localparam logic [T_W-1:0] T_GUARD = T_W'(5);

    typedef enum logic [2:0] {
        RST_CLR = 3'd0,
        FETCH_L = 3'd1,
        FETCH_H = 3'd2,
        DECODE  = 3'd3,
        EXEC    = 3'd4,
        HALT    = 3'd5
    } state_t;

    localparam logic [OPC_W-1:0] OP_BRA = 6'h00;
    localparam logic [OPC_W-1:0] OP_BNE = 6'h01;
    localparam logic [OPC_W-1:0] OP_LD  = 6'h02;
    localparam logic [OPC_W-1:0] OP_ST  = 6'h03;
    localparam logic [OPC_W-1:0] OP_ADD = 6'h04;
    localparam logic [OPC_W-1:0] OP_SUB = 6'h05;
    localparam logic [OPC_W-1:0] OP_AND = 6'h06;
    localparam logic [OPC_W-1:0] OP_INC = 6'h07;
    localparam logic [OPC_W-1:0] OP_HLT = 6'h3F;

    localparam logic [4:0] ALU_PASS_A = 5'b10000;
    localparam logic [4:0] ALU_ADD    = 5'b10100;
    localparam logic [4:0] ALU_SUB    = 5'b10110;
    localparam logic [4:0] ALU_AND    = 5'b10111;

    localparam logic [2:0] FUN_DEC  = 3'b000;
    localparam logic [2:0] FUN_INC  = 3'b001;
    localparam logic [2:0] FUN_LOAD = 3'b010;
    localparam logic [2:0] FUN_CLR  = 3'b011;

    // ARF output-select codes
    localparam logic [1:0] ARF_PC = 2'b00;
    localparam logic [1:0] ARF_AR = 2'b10;
    localparam logic [1:0] ARF_SP = 2'b11;

    // ARF write-enable bits {PC, AR, SP}
    localparam logic [2:0] ARF_SEL_PC  = 3'b100;
    localparam logic [2:0] ARF_SEL_AR  = 3'b010;
    localparam logic [2:0] ARF_SEL_SP  = 3'b001;
    localparam logic [2:0] ARF_SEL_ALL = 3'b111;

    // RF output selects for scratch registers, scratch write-enables {S1,S2,S3,S4}
    localparam logic [2:0] RF_OUT_S1  = 3'b100;
    localparam logic [2:0] RF_OUT_S2  = 3'b101;
    localparam logic [3:0] SCR_SEL_S1 = 4'b1000;
    localparam logic [3:0] SCR_SEL_S2 = 4'b0100;

    localparam logic [1:0] MUXA_ALU  = 2'd0;
    localparam logic [1:0] MUXA_OUTC = 2'd1;
    localparam logic [1:0] MUXA_MEM  = 2'd2;
    localparam logic [1:0] MUXB_ALU  = 2'd0;
    localparam logic [1:0] MUXB_OUTC = 2'd1;
    localparam logic [1:0] MUXB_IR   = 2'd3;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [1:0]       rsel;
        logic             s;
        logic [2:0]       dst;
        logic [2:0]       src1;
        logic [2:0]       src2;
    } instr_t;

    // Both formats overlap in IR[9:0]; keep every view so EXEC can pick.
    function automatic instr_t decode_instr(input logic [IR_W-1:0] ir);
        instr_t f;
        f.opcode = ir[15:10];
        f.rsel   = ir[9:8];
        f.s      = ir[9];
        f.dst    = ir[8:6];
        f.src1   = ir[5:3];
        f.src2   = ir[2:0];
        return f;
    endfunction

    // R1..R4 write-enable, R1 in the MSB
    function automatic logic [3:0] rf_onehot(input logic [1:0] idx);
        return 4'b1000 >> idx;
    endfunction

    function automatic logic [2:0] arf_onehot(input logic [1:0] code);
        case (code)
            ARF_AR:  return ARF_SEL_AR;
            ARF_SP:  return ARF_SEL_SP;
            default: return ARF_SEL_PC;
        endcase
    endfunction

    function automatic logic [4:0] alu_code(input logic [OPC_W-1:0] opcode);
        case (opcode)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/cu_seq_counter.sv
// Execute-phase timing counter T.
// Ports: clk, rst (sync, active-high), clr (return to T0), inc (advance), t (count).
module cu_seq_counter
    import cu_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           inc,
    output logic [T_W-1:0] t
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            t <= '0;
        end else if (inc) begin
            t <= t + T_W'(1);
        end
    end

endmodule

// File: rtl/hardwired_control_unit.sv
// Hardwired sequencer for ArithmeticLogicUnitSystem: two fetch cycles, one
// decode cycle and 1-3 execute cycles per instruction. Outputs are Moore
// decodes of the state register, T and the latched instruction fields, except
// the BNE PC write which looks at Z during its single execute cycle.
// Ports: Clock, Reset (sync, active-high), IROut, FlagsOut in; RF_*, ALU_*,
// ARF_*, IR_LH/IR_Write, Mem_WR/Mem_CS, MuxA/B/CSel datapath controls out;
// Halted out only when CU_HALT_EN is defined (opcode 0x3F then parks the FSM
// in HALT until Reset; otherwise 0x3F is a NOP).
module hardwired_control_unit
    import cu_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic [IR_W-1:0]   IROut,
    input  logic [FLAG_W-1:0] FlagsOut,
    output logic [2:0]        RF_OutASel,
    output logic [2:0]        RF_OutBSel,
    output logic [2:0]        RF_FunSel,
    output logic [3:0]        RF_RegSel,
    output logic [3:0]        RF_ScrSel,
    output logic [4:0]        ALU_FunSel,
    output logic              ALU_WF,
    output logic [1:0]        ARF_OutCSel,
    output logic [1:0]        ARF_OutDSel,
    output logic [2:0]        ARF_FunSel,
    output logic [2:0]        ARF_RegSel,
    output logic              IR_LH,
    output logic              IR_Write,
    output logic              Mem_WR,
    output logic              Mem_CS,
    output logic [1:0]        MuxASel,
    output logic [1:0]        MuxBSel,
    output logic              MuxCSel
`ifdef CU_HALT_EN
    ,
    output logic              Halted
`endif
);

`ifdef CU_HALT_EN
    localparam logic HALT_EN = 1'b1;
`else
    localparam logic HALT_EN = 1'b0;
`endif

    state_t         state;
    state_t         state_next;
    instr_t         instr_q;
    logic [T_W-1:0] t;
    logic           exec_last;
    logic           src1_arf;
    logic           src2_arf;
    logic           dst_arf;
    logic           stage_s1;
    logic [T_W-1:0] alu_last_t;
    logic [OPC_W-1:0] dec_opcode;
    logic           unused_flags;

    assign unused_flags = ^FlagsOut[FLAG_Z-1:0];
    assign dec_opcode   = IROut[15:10];

    // Operand codes with bit 2 clear live in the ARF and must go through scratch.
    assign src1_arf   = ~instr_q.src1[2];
    assign src2_arf   = ~instr_q.src2[2];
    assign dst_arf    = ~instr_q.dst[2];
    assign alu_last_t = T_W'(src1_arf) + T_W'(src2_arf);
    assign stage_s1   = (t == '0) && src1_arf;

    // State register; Reset overrides mid-instruction
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= RST_CLR;
        end else begin
            state <= state_next;
        end
    end

    // Instruction fields captured once per instruction
    always_ff @(posedge Clock) begin
        if (state == DECODE) begin
            instr_q <= decode_instr(IROut);
        end
    end

    cu_seq_counter u_seq (
        .clk (Clock),
        .rst (Reset),
        .clr ((state != EXEC) || (state_next != EXEC)),
        .inc (state == EXEC),
        .t   (t)
    );

    // Final execute cycle per opcode
    always_comb begin
        exec_last = 1'b1;
        case (instr_q.opcode)
            OP_ST:                 exec_last = (t == T_W'(1));
            OP_ADD, OP_SUB, OP_AND: exec_last = (t == alu_last_t);
            OP_INC:                exec_last = (instr_q.dst == instr_q.src1) ? (t == '0)
                                                                             : (t == T_W'(1));
            default:               exec_last = 1'b1;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            RST_CLR: state_next = FETCH_L;
            FETCH_L: state_next = FETCH_H;
            FETCH_H: state_next = DECODE;
            DECODE: begin
                if (dec_opcode <= OP_INC) begin
                    state_next = EXEC;
                end else if (HALT_EN && (dec_opcode == OP_HLT)) begin
                    state_next = HALT;
                end else begin
                    state_next = FETCH_L;
                end
            end
            EXEC: begin
                if (exec_last || (t >= T_GUARD)) begin
                    state_next = FETCH_L;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = RST_CLR;
        endcase
    end

    // Datapath control decode
    always_comb begin
        RF_OutASel  = '0;
        RF_OutBSel  = '0;
        RF_FunSel   = FUN_DEC;
        RF_RegSel   = '0;
        RF_ScrSel   = '0;
        ALU_FunSel  = '0;
        ALU_WF      = 1'b0;
        ARF_OutCSel = '0;
        ARF_OutDSel = '0;
        ARF_FunSel  = FUN_DEC;
        ARF_RegSel  = '0;
        IR_LH       = 1'b0;
        IR_Write    = 1'b0;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        MuxASel     = '0;
        MuxBSel     = '0;
        MuxCSel     = 1'b0;
`ifdef CU_HALT_EN
        Halted      = 1'b0;
`endif
        case (state)
            RST_CLR: begin
                ARF_FunSel = FUN_CLR;
                ARF_RegSel = ARF_SEL_ALL;
                RF_FunSel  = FUN_CLR;
                RF_RegSel  = 4'b1111;
                RF_ScrSel  = 4'b1111;
            end
            FETCH_L, FETCH_H: begin
                ARF_OutDSel = ARF_PC;
                Mem_CS      = 1'b0;
                IR_LH       = (state == FETCH_H);
                IR_Write    = 1'b1;
                ARF_FunSel  = FUN_INC;
                ARF_RegSel  = ARF_SEL_PC;
            end
            EXEC: begin
                case (instr_q.opcode)
                    OP_BRA, OP_BNE: begin
                        MuxBSel    = MUXB_IR;
                        ARF_FunSel = FUN_LOAD;
                        if ((instr_q.opcode == OP_BRA) || !FlagsOut[FLAG_Z]) begin
                            ARF_RegSel = ARF_SEL_PC;
                        end
                    end
                    OP_LD: begin
                        ARF_OutDSel = ARF_AR;
                        Mem_CS      = 1'b0;
                        MuxASel     = MUXA_MEM;
                        RF_FunSel   = FUN_LOAD;
                        RF_RegSel   = rf_onehot(instr_q.rsel);
                    end
                    OP_ST: begin
                        // Low byte at T0, high byte at T1; AR steps after the high byte
                        RF_OutASel  = {1'b0, instr_q.rsel};
                        ALU_FunSel  = ALU_PASS_A;
                        ARF_OutDSel = ARF_AR;
                        Mem_CS      = 1'b0;
                        Mem_WR      = 1'b1;
                        MuxCSel     = (t != '0);
                        if (t != '0) begin
                            ARF_FunSel = FUN_INC;
                            ARF_RegSel = ARF_SEL_AR;
                        end
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        if (t < alu_last_t) begin
                            // Stage an ARF source into S1 (SRC1) or S2 (SRC2)
                            ARF_OutCSel = stage_s1 ? instr_q.src1[1:0] : instr_q.src2[1:0];
                            MuxASel     = MUXA_OUTC;
                            RF_FunSel   = FUN_LOAD;
                            RF_ScrSel   = stage_s1 ? SCR_SEL_S1 : SCR_SEL_S2;
                        end else begin
                            RF_OutASel = src1_arf ? RF_OUT_S1 : {1'b0, instr_q.src1[1:0]};
                            RF_OutBSel = src2_arf ? RF_OUT_S2 : {1'b0, instr_q.src2[1:0]};
                            ALU_FunSel = alu_code(instr_q.opcode);
                            ALU_WF     = instr_q.s;
                            if (dst_arf) begin
                                MuxBSel    = MUXB_ALU;
                                ARF_FunSel = FUN_LOAD;
                                ARF_RegSel = arf_onehot(instr_q.dst[1:0]);
                            end else begin
                                MuxASel   = MUXA_ALU;
                                RF_FunSel = FUN_LOAD;
                                RF_RegSel = rf_onehot(instr_q.dst[1:0]);
                            end
                        end
                    end
                    OP_INC: begin
                        if (t == '0) begin
                            if (dst_arf) begin
                                ARF_FunSel = FUN_INC;
                                ARF_RegSel = arf_onehot(instr_q.dst[1:0]);
                            end else begin
                                RF_FunSel = FUN_INC;
                                RF_RegSel = rf_onehot(instr_q.dst[1:0]);
                            end
                        end else begin
                            // Copy SRC1 into DST through OutC (ARF source) or the ALU
                            if (src1_arf) begin
                                ARF_OutCSel = instr_q.src1[1:0];
                                MuxASel     = MUXA_OUTC;
                                MuxBSel     = MUXB_OUTC;
                            end else begin
                                RF_OutASel = {1'b0, instr_q.src1[1:0]};
                                ALU_FunSel = ALU_PASS_A;
                                MuxASel    = MUXA_ALU;
                                MuxBSel    = MUXB_ALU;
                            end
                            if (dst_arf) begin
                                ARF_FunSel = FUN_LOAD;
                                ARF_RegSel = arf_onehot(instr_q.dst[1:0]);
                            end else begin
                                RF_FunSel = FUN_LOAD;
                                RF_RegSel = rf_onehot(instr_q.dst[1:0]);
                            end
                        end
                    end
                    default: ;
                endcase
            end
            HALT: begin
`ifdef CU_HALT_EN
                Halted = 1'b1;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hardwired_control_unit.sv
// Directed self-checking bench for hardwired_control_unit: a table of single
// instructions checked at their first execute cycle, then hand-written
// sequences for multi-cycle ops, mid-instruction reset and HLT.
module tb_hardwired_control_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] IROut;
    logic [3:0]  FlagsOut;
    logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
    logic [3:0]  RF_RegSel, RF_ScrSel;
    logic [4:0]  ALU_FunSel;
    logic        ALU_WF;
    logic [1:0]  ARF_OutCSel, ARF_OutDSel;
    logic [2:0]  ARF_FunSel, ARF_RegSel;
    logic        IR_LH, IR_Write, Mem_WR, Mem_CS;
    logic [1:0]  MuxASel, MuxBSel;
    logic        MuxCSel;
`ifdef CU_HALT_EN
    logic        Halted;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    hardwired_control_unit dut (
        .Clock(Clock), .Reset(Reset), .IROut(IROut), .FlagsOut(FlagsOut),
        .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
        .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel),
        .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF),
        .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
        .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
        .IR_LH(IR_LH), .IR_Write(IR_Write), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
        .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel)
`ifdef CU_HALT_EN
        , .Halted(Halted)
`endif
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [15:0] ir;
        logic [3:0]  flags;
        int          n_exec;
        logic [3:0]  regsel;
        logic [3:0]  scrsel;
        logic [2:0]  rf_fun;
        logic [2:0]  arf_sel;
        logic [2:0]  arf_fun;
        logic [4:0]  alu;
        logic        wf;
        logic        chk_ab;
        logic [2:0]  outa;
        logic [2:0]  outb;
        logic [1:0]  muxa;
        logic [1:0]  muxb;
        logic        muxc;
        logic [1:0]  outd;
        logic        cs;
        logic        wr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    function automatic vec_t mkv(input logic [15:0] ir, input logic [3:0] fl, input int n);
        vec_t v;
        v.ir = ir; v.flags = fl; v.n_exec = n;
        v.regsel = 4'b0; v.scrsel = 4'b0; v.rf_fun = 3'b0; v.arf_sel = 3'b0; v.arf_fun = 3'b0;
        v.alu = 5'b0; v.wf = 1'b0; v.chk_ab = 1'b0; v.outa = 3'b0; v.outb = 3'b0;
        v.muxa = 2'b0; v.muxb = 2'b0; v.muxc = 1'b0; v.outd = 2'b0; v.cs = 1'b1; v.wr = 1'b0;
        return v;
    endfunction

    // Drive an instruction through FETCH_L, FETCH_H and DECODE; ends at EXEC T0
    task automatic run_front(input logic [15:0] ir, input logic [3:0] fl);
        IROut = ir;
        FlagsOut = fl;
        chk("fetch_l", {IR_Write, IR_LH, Mem_CS, Mem_WR, ARF_OutDSel, ARF_RegSel, ARF_FunSel},
            {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b100, 3'b001});
        step();
        chk("fetch_h", {IR_Write, IR_LH, Mem_CS, ARF_OutDSel}, {1'b1, 1'b1, 1'b0, 2'b00});
        step();
        chk("decode_idle", {IR_Write, Mem_CS, Mem_WR, RF_RegSel, RF_ScrSel, ARF_RegSel, ALU_WF},
            {1'b0, 1'b1, 1'b0, 4'b0, 4'b0, 3'b0, 1'b0});
        step();
    endtask

    task automatic check_exec(input vec_t v);
        chk("ex_rf_regsel", RF_RegSel, v.regsel);
        chk("ex_rf_scrsel", RF_ScrSel, v.scrsel);
        chk("ex_arf_regsel", ARF_RegSel, v.arf_sel);
        chk("ex_alu_wf", ALU_WF, v.wf);
        chk("ex_mem", {Mem_CS, Mem_WR}, {v.cs, v.wr});
        if ((v.regsel | v.scrsel) != 4'b0) begin
            chk("ex_rf_funsel", RF_FunSel, v.rf_fun);
            chk("ex_muxa", MuxASel, v.muxa);
        end
        if (v.arf_sel != 3'b0) chk("ex_arf_funsel", ARF_FunSel, v.arf_fun);
        if (v.arf_fun == 3'b010) chk("ex_muxb", MuxBSel, v.muxb);
        if (v.alu != 5'b0) chk("ex_alu_funsel", ALU_FunSel, v.alu);
        if (v.chk_ab) chk("ex_outab", {RF_OutASel, RF_OutBSel}, {v.outa, v.outb});
        if (!v.cs) chk("ex_outd", ARF_OutDSel, v.outd);
        if (v.wr) chk("ex_muxc", MuxCSel, v.muxc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   cnt;

        // BRA 0x12
        v = mkv(16'h0012, 4'b0000, 1);
        v.arf_sel = 3'b100; v.arf_fun = 3'b010; v.muxb = 2'd3;
        vecs.push_back(v);
        // BNE with Z=1: no write
        v = mkv(16'h0405, 4'b1000, 1);
        vecs.push_back(v);
        // BNE with Z=0 (other flags set): PC loaded
        v = mkv(16'h0405, 4'b0111, 1);
        v.arf_sel = 3'b100; v.arf_fun = 3'b010; v.muxb = 2'd3;
        vecs.push_back(v);
        // LD R2
        v = mkv(16'h0900, 4'b0000, 1);
        v.regsel = 4'b0100; v.rf_fun = 3'b010; v.muxa = 2'd2; v.cs = 1'b0; v.outd = 2'b10;
        vecs.push_back(v);
        // ADD S=1 R1 <- R2 + R3
        v = mkv(16'h132E, 4'b0000, 1);
        v.regsel = 4'b1000; v.rf_fun = 3'b010; v.muxa = 2'd0; v.alu = 5'b10100; v.wf = 1'b1;
        v.chk_ab = 1'b1; v.outa = 3'b001; v.outb = 3'b010;
        vecs.push_back(v);
        // SUB S=0 R4 <- R1 - R2
        v = mkv(16'h15E5, 4'b0000, 1);
        v.regsel = 4'b0001; v.rf_fun = 3'b010; v.muxa = 2'd0; v.alu = 5'b10110; v.wf = 1'b0;
        v.chk_ab = 1'b1; v.outa = 3'b000; v.outb = 3'b001;
        vecs.push_back(v);
        // AND S=1 R3 <- SP & R4: T0 stages SP into S1
        v = mkv(16'h1B9F, 4'b0000, 2);
        v.scrsel = 4'b1000; v.rf_fun = 3'b010; v.muxa = 2'd1;
        vecs.push_back(v);
        // Illegal opcode 0x20: straight back to fetch
        v = mkv(16'h8000, 4'b0000, 0);
        vecs.push_back(v);
        // ST R1, T0 (low byte)
        v = mkv(16'h0C00, 4'b0000, 2);
        v.cs = 1'b0; v.wr = 1'b1; v.outd = 2'b10; v.muxc = 1'b0; v.alu = 5'b10000;
        vecs.push_back(v);
        // INC R2 with DST == SRC1: single cycle
        v = mkv(16'h1D68, 4'b0000, 1);
        v.regsel = 4'b0100; v.rf_fun = 3'b001;
        vecs.push_back(v);

        // Reset sequence
        Reset = 1'b1; IROut = 16'h0; FlagsOut = 4'h0;
        step();
        chk("rst_clr", {ARF_FunSel, ARF_RegSel, RF_FunSel, RF_RegSel, RF_ScrSel, Mem_CS, Mem_WR, IR_Write, ALU_WF},
            {3'b011, 3'b111, 3'b011, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0});
        step();
        Reset = 1'b0;
        chk("rst_clr_last", {ARF_FunSel, ARF_RegSel, IR_Write}, {3'b011, 3'b111, 1'b0});
        step();

        foreach (vecs[i]) begin
            run_front(vecs[i].ir, vecs[i].flags);
            if (vecs[i].n_exec > 0) begin
                check_exec(vecs[i]);
                repeat (vecs[i].n_exec) step();
            end
        end

        // ADD writes R1 during exactly one cycle
        run_front(16'h132E, 4'b0000);
        cnt = 0;
        if (RF_RegSel == 4'b1000) cnt++;
        step();
        if (RF_RegSel == 4'b1000) cnt++;
        chk("add_r1_once", cnt, 1);

        // AND with an ARF source: op cycle at T1 from S1
        run_front(16'h1B9F, 4'b0000);
        chk("and_t0_stage", {ARF_OutCSel, RF_ScrSel, MuxASel, ALU_WF}, {2'b11, 4'b1000, 2'd1, 1'b0});
        step();
        chk("and_t1_op", {RF_OutASel, RF_OutBSel, ALU_FunSel, ALU_WF, RF_RegSel, RF_ScrSel, MuxASel, RF_FunSel},
            {3'b100, 3'b011, 5'b10111, 1'b1, 4'b0010, 4'b0000, 2'd0, 3'b010});
        step();

        // ADD AR <- PC + SP: two staging cycles, op at T2 into the ARF
        run_front(16'h1083, 4'b0000);
        chk("add2_t0", {ARF_OutCSel, RF_ScrSel, ALU_WF}, {2'b00, 4'b1000, 1'b0});
        step();
        chk("add2_t1", {ARF_OutCSel, RF_ScrSel, ALU_WF}, {2'b11, 4'b0100, 1'b0});
        step();
        chk("add2_t2", {RF_OutASel, RF_OutBSel, ALU_FunSel, ALU_WF, ARF_RegSel, ARF_FunSel, MuxBSel, RF_RegSel},
            {3'b100, 3'b101, 5'b10100, 1'b0, 3'b010, 3'b010, 2'd0, 4'b0});
        step();

        // ST R2: high byte and AR increment at T1
        run_front(16'h0D00, 4'b0000);
        chk("st_t0", {Mem_WR, MuxCSel, RF_OutASel, ARF_RegSel}, {1'b1, 1'b0, 3'b001, 3'b000});
        step();
        chk("st_t1", {Mem_CS, Mem_WR, MuxCSel, ARF_FunSel, ARF_RegSel}, {1'b0, 1'b1, 1'b1, 3'b001, 3'b010});
        step();

        // INC R3, R1: increment then copy
        run_front(16'h1DA0, 4'b0000);
        chk("inc_t0", {RF_FunSel, RF_RegSel}, {3'b001, 4'b0010});
        step();
        chk("inc_t1", {RF_OutASel, ALU_FunSel, MuxASel, RF_FunSel, RF_RegSel},
            {3'b000, 5'b10000, 2'd0, 3'b010, 4'b0010});
        step();

        // Reset during ST T0
        run_front(16'h0C00, 4'b0000);
        chk("st_pre_reset", Mem_WR, 1'b1);
        Reset = 1'b1;
        step();
        chk("mid_reset", {Mem_WR, Mem_CS, ARF_FunSel, ARF_RegSel, RF_RegSel}, {1'b0, 1'b1, 3'b011, 3'b111, 4'b1111});
        chk("mid_reset_t", dut.u_seq.t, 3'd0);
        Reset = 1'b0;
        step();

        // HLT
        run_front(16'hFC00, 4'b0000);
`ifdef CU_HALT_EN
        for (int k = 0; k < 20; k++) begin
            chk("halt_idle", {Halted, IR_Write, Mem_CS, Mem_WR, ARF_RegSel, RF_RegSel, RF_ScrSel, ALU_WF},
                {1'b1, 1'b0, 1'b1, 1'b0, 3'b0, 4'b0, 4'b0, 1'b0});
            step();
        end
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        step();
        chk("halt_exit", {Halted, IR_Write, IR_LH}, {1'b0, 1'b1, 1'b0});
`else
        chk("hlt_nop", {IR_Write, IR_LH, Mem_CS}, {1'b1, 1'b0, 1'b0});
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
